uart_fifo_ctrl: RTL and testbench
=================================

# uart_fifo_ctrl

Parametrised, clocked successor to the SD-to-UART glue controller. Buffers bytes from the SD host side in a TX FIFO and drives the UART transmitter's start/busy handshake one word at a time. Captures received words in an RX FIFO with overrun detection. Sits between the SD host controller core and the UART TX/RX shift engines, and replaces per-register enable steering with FIFO handshakes.

## Interface
Parameters:
- DATA_W, 8, word width on both sides
- TX_DEPTH, 8, TX FIFO entries; power of two, ≥2
- RX_DEPTH, 8, RX FIFO entries; power of two, ≥2
- ACK_TIMEOUT, 16, max cycles to wait for uart_tx_sending to rise after a start pulse; ≥1

Ports:
- Clocking is decided: one clock, clk; reset is rst, asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  async active-high reset
- sd_tx_en  in  1  push sd_tx_data into the TX FIFO
- sd_tx_data  in  DATA_W  word from the SD side
- sd_tx_ready  out  1  TX FIFO not full
- sd_rx_rd  in  1  pop the RX FIFO head
- sd_rx_data  out  DATA_W  RX FIFO head (first-word fall-through)
- sd_rx_valid  out  1  RX FIFO not empty
- uart_tx_en  out  1  one-cycle start pulse to the UART transmitter
- uart_tx_data  out  DATA_W  registered word being sent; held until the next start
- uart_tx_sending  in  1  UART transmitter busy
- uart_rx_valid  in  1  one-cycle strobe: uart_rx_data is valid
- uart_rx_data  in  DATA_W  received word
- status_clr  in  1  clears the sticky flags
- tx_count  out  $clog2(TX_DEPTH+1)  TX FIFO occupancy
- rx_count  out  $clog2(RX_DEPTH+1)  RX FIFO occupancy
- rx_overrun  out  1  sticky: an RX word was dropped
- tx_timeout  out  1  sticky: the transmitter never acknowledged a start

## Operation
- TX push: accepted only when sd_tx_en=1 and sd_tx_ready=1. A push while full is ignored: no count change, no flag.
- TX FSM, four states:
  - IDLE: when the FIFO is non-empty, latch the head into uart_tx_data, pop, and go to START.
  - START: uart_tx_en=1 for this state only; go to WAIT_ACK.
  - WAIT_ACK: on uart_tx_sending=1, go to BUSY. After ACK_TIMEOUT cycles without it, set tx_timeout and go to IDLE; the word is lost.
  - BUSY: on uart_tx_sending=0, go to IDLE.
- uart_tx_sending is ignored in IDLE and START.
- RX push: happens on uart_rx_valid. If the FIFO is full, the word is dropped and rx_overrun is set.
- RX pop: sd_rx_rd pops only when sd_rx_valid=1; a pop when empty is ignored.
- Full/empty are evaluated before the current cycle's operations. Simultaneous push and pop:
  - not full and not empty: both occur, count unchanged.
  - full: the pop occurs and the push is dropped; for RX this sets the overrun flag.
  - empty: the push occurs and the pop is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally; count is tracked separately, so full and empty are unambiguous.
- Sticky flags: status_clr clears them. If status_clr and a set event occur in the same cycle, the set wins.

## Timing
- Reset values:
  - state IDLE; pointers and counts 0
  - sd_tx_ready=1, sd_rx_valid=0
  - uart_tx_en=0, uart_tx_data=0
  - rx_overrun=0, tx_timeout=0
  - sd_rx_data=0 while empty is not required (don't-care)
- All outputs are registered except sd_rx_data, sd_rx_valid and sd_tx_ready, which are derived directly from FIFO state.
- Latency into an idle FIFO with the FSM in IDLE:
  - push sampled at edge E0; tx_count=1 after E0.
  - FSM enters START at E1; uart_tx_en is high from E1 to E2; tx_count returns to 0 after E1.
- Minimum back-to-back spacing: START, then ≥1 WAIT_ACK cycle, then ≥1 BUSY cycle, then IDLE. That is at least 4 cycles between start pulses.
- RX: a word strobed at edge E0 gives sd_rx_valid=1 after E0.
- A reset asserted mid-frame returns the FSM to IDLE immediately and flushes both FIFOs. uart_tx_en drops asynchronously.

## Structure
- Shared package uart_pkg holds the TX FSM state typedef (IDLE, START, WAIT_ACK, BUSY) and a helper function for the count width.
- Sub-module uart_sync_fifo (parameters W, DEPTH):
  - provides push, pop, full, empty, count and first-word fall-through head
  - is instantiated once for TX and once for RX
- The top level holds the FSM, the timeout counter and the sticky flags.

## Test plan
- Reset, then push 0xA5 -> uart_tx_en pulses exactly 1 cycle, 2 cycles after the push, with uart_tx_data=0xA5. Holding uart_tx_sending high 10 cycles then low -> FSM in IDLE, tx_count=0.
- Push 9 words 0x01..0x09 with DATA_W=8, TX_DEPTH=8, the transmitter held busy -> sd_tx_ready deasserts once full and 0x09 is dropped. Releasing the transmitter sends the accepted words in order, none lost.
- Never raise uart_tx_sending after a start -> tx_timeout=1 after 16 cycles in WAIT_ACK. Assert status_clr -> flag 0; the next word still transmits.
- Strobe 9 RX words with no reads -> rx_count=8, rx_overrun=1. Reads return the first 8 words in order, then sd_rx_valid=0.
- With the RX FIFO full, assert uart_rx_valid and sd_rx_rd in the same cycle -> head popped, new word dropped, rx_overrun=1, rx_count=7.
- Assert rst while in BUSY with 3 words queued -> next cycle shows tx_count=0, uart_tx_en=0 and the FSM in IDLE; the next push transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the SD-to-UART FIFO controller: TX FSM states and count sizing.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      START    = 2'd1,
      WAIT_ACK = 2'd2,
      BUSY     = 2'd3
   } tx_state_e;

   // Occupancy counters must hold the value DEPTH itself, hence DEPTH+1.
   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head and separate occupancy count.
// Push when full and pop when empty are ignored; full/empty reflect state before this cycle.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  logic [W-1:0]              dat_i,
   output logic [W-1:0]              head_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [count_w(DEPTH)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_w(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + CW'(1);
      else if (do_pop && !do_push)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Storage is not reset: a flush only needs the pointers and count cleared.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= dat_i;
   end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// SD-to-UART glue: TX FIFO feeding a start/busy handshake FSM, RX FIFO with overrun flag.
// Sticky tx_timeout/rx_overrun; a set event beats status_clr in the same cycle.
module uart_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int TX_DEPTH    = 8,
   parameter int RX_DEPTH    = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sd_tx_en,
   input  logic [DATA_W-1:0]            sd_tx_data,
   output logic                         sd_tx_ready,
   input  logic                         sd_rx_rd,
   output logic [DATA_W-1:0]            sd_rx_data,
   output logic                         sd_rx_valid,
   output logic                         uart_tx_en,
   output logic [DATA_W-1:0]            uart_tx_data,
   input  logic                         uart_tx_sending,
   input  logic                         uart_rx_valid,
   input  logic [DATA_W-1:0]            uart_rx_data,
   input  logic                         status_clr,
   output logic [count_w(TX_DEPTH)-1:0] tx_count,
   output logic [count_w(RX_DEPTH)-1:0] rx_count,
   output logic                         rx_overrun,
   output logic                         tx_timeout
);

   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   tx_state_e         state_q;
   logic [TW-1:0]     timer_q;
   logic              uart_tx_en_q, tx_timeout_q, rx_overrun_q;
   logic [DATA_W-1:0] uart_tx_data_q, tx_head;
   logic              tx_full, tx_empty, tx_pop, rx_full, rx_empty, to_set;

   uart_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push_i(sd_tx_en), .pop_i(tx_pop), .dat_i(sd_tx_data),
      .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
   );

   uart_sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push_i(uart_rx_valid), .pop_i(sd_rx_rd), .dat_i(uart_rx_data),
      .head_o(sd_rx_data), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
   );

   assign sd_tx_ready  = !tx_full;
   assign sd_rx_valid  = !rx_empty;
   assign tx_pop       = (state_q == IDLE) && !tx_empty;
   assign to_set       = (state_q == WAIT_ACK) && !uart_tx_sending && (timer_q == TW'(ACK_TIMEOUT - 1));
   assign uart_tx_en   = uart_tx_en_q;
   assign uart_tx_data = uart_tx_data_q;
   assign tx_timeout   = tx_timeout_q;
   assign rx_overrun   = rx_overrun_q;

   // The start pulse is registered on the IDLE->START transition so it is high exactly in START.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         uart_tx_en_q   <= 1'b0;
         uart_tx_data_q <= '0;
         tx_timeout_q   <= 1'b0;
      end else begin
         uart_tx_en_q <= 1'b0;
         case (state_q)
            IDLE: if (!tx_empty) begin
               uart_tx_data_q <= tx_head;
               uart_tx_en_q   <= 1'b1;
               state_q        <= START;
            end
            START: begin
               timer_q <= '0;
               state_q <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (uart_tx_sending)
                  state_q <= BUSY;
               else if (to_set)
                  state_q <= IDLE;
               else
                  timer_q <= timer_q + TW'(1);
            end
            BUSY: if (!uart_tx_sending) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (to_set)
            tx_timeout_q <= 1'b1;
         else if (status_clr)
            tx_timeout_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rx_overrun_q <= 1'b0;
      else if (uart_rx_valid && rx_full)
         rx_overrun_q <= 1'b1;
      else if (status_clr)
         rx_overrun_q <= 1'b0;
   end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: TX handshake, TX/RX full handling, timeout, reset flush.
module tb_uart_fifo_ctrl;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sd_tx_en = 1'b0;
   logic [7:0] sd_tx_data = '0;
   logic       sd_tx_ready;
   logic       sd_rx_rd = 1'b0;
   logic [7:0] sd_rx_data;
   logic       sd_rx_valid;
   logic       uart_tx_en;
   logic [7:0] uart_tx_data;
   logic       uart_tx_sending;
   logic       uart_rx_valid = 1'b0;
   logic [7:0] uart_rx_data = '0;
   logic       status_clr = 1'b0;
   logic [3:0] tx_count, rx_count;
   logic       rx_overrun, tx_timeout;

   logic       auto_ack = 1'b0;
   logic       man_sending = 1'b0;
   logic       model_busy = 1'b0;
   int         bcnt = 0;
   logic [7:0] sent_q[$];
   int         checks = 0;
   int         failures = 0;

   assign uart_tx_sending = auto_ack ? model_busy : man_sending;

   uart_fifo_ctrl dut (
      .clk(clk), .rst(rst), .sd_tx_en(sd_tx_en), .sd_tx_data(sd_tx_data), .sd_tx_ready(sd_tx_ready),
      .sd_rx_rd(sd_rx_rd), .sd_rx_data(sd_rx_data), .sd_rx_valid(sd_rx_valid),
      .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_sending(uart_tx_sending),
      .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .status_clr(status_clr),
      .tx_count(tx_count), .rx_count(rx_count), .rx_overrun(rx_overrun), .tx_timeout(tx_timeout)
   );

   always #5 clk = ~clk;

   // Transmitter model: records each start and, when enabled, stays busy for a few cycles.
   always @(negedge clk) begin
      if (uart_tx_en) begin
         sent_q.push_back(uart_tx_data);
         bcnt = 3;
      end else if (bcnt > 0) begin
         bcnt = bcnt - 1;
      end
      model_busy = (bcnt != 0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_tx(input logic [7:0] d);
      sd_tx_en = 1'b1;
      sd_tx_data = d;
      tick();
      sd_tx_en = 1'b0;
   endtask

   task automatic strobe_rx(input logic [7:0] d);
      uart_rx_valid = 1'b1;
      uart_rx_data = d;
      tick();
      uart_rx_valid = 1'b0;
   endtask

   task automatic wait_sent(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && sent_q.size() < n; i++) tick();
      chk(tag, 32'(sent_q.size()), 32'(n));
   endtask

   initial begin
      int base;
      tick(3);
      rst = 1'b0;
      tick();
      chk("rst_tx_ready", 32'(sd_tx_ready), 32'd1);
      chk("rst_rx_valid", 32'(sd_rx_valid), 32'd0);
      chk("rst_tx_en", 32'(uart_tx_en), 32'd0);
      chk("rst_tx_data", 32'(uart_tx_data), 32'h00);
      chk("rst_flags", {30'd0, rx_overrun, tx_timeout}, 32'd0);
      chk("rst_counts", {24'd0, tx_count, rx_count}, 32'd0);

      // Single word: pulse two cycles after push, exactly one cycle wide.
      push_tx(8'hA5);
      chk("t1_count_e0", 32'(tx_count), 32'd1);
      chk("t1_en_e0", 32'(uart_tx_en), 32'd0);
      tick();
      chk("t1_en_e1", 32'(uart_tx_en), 32'd1);
      chk("t1_data", 32'(uart_tx_data), 32'hA5);
      chk("t1_count_e1", 32'(tx_count), 32'd0);
      tick();
      chk("t1_en_e2", 32'(uart_tx_en), 32'd0);
      man_sending = 1'b1;
      tick(10);
      man_sending = 1'b0;
      tick(2);
      chk("t1_state_idle", 32'(dut.state_q), 32'(IDLE));
      chk("t1_pulses", 32'(sent_q.size()), 32'd1);

      // TX full: park the FSM in BUSY, then offer 9 words.
      base = sent_q.size();
      man_sending = 1'b1;
      push_tx(8'hEE);
      tick(3);
      chk("t2_busy", 32'(dut.state_q), 32'(BUSY));
      for (int i = 1; i <= 8; i++) push_tx(8'(i));
      chk("t2_count8", 32'(tx_count), 32'd8);
      chk("t2_ready0", 32'(sd_tx_ready), 32'd0);
      push_tx(8'h09);
      chk("t2_count_drop", 32'(tx_count), 32'd8);
      auto_ack = 1'b1;
      man_sending = 1'b0;
      wait_sent("t2_sent_n", base + 9, 200);
      tick(6);
      chk("t2_count0", 32'(tx_count), 32'd0);
      chk("t2_word_ee", 32'(sent_q[base]), 32'hEE);
      for (int i = 1; i <= 8; i++)
         if (base + i < sent_q.size()) chk("t2_word", 32'(sent_q[base + i]), 32'(i));
      chk("t2_no_extra", 32'(sent_q.size()), 32'(base + 9));

      // Ack timeout after 16 cycles in WAIT_ACK.
      auto_ack = 1'b0;
      man_sending = 1'b0;
      push_tx(8'h3C);
      tick();
      chk("t3_en", 32'(uart_tx_en), 32'd1);
      tick(16);
      chk("t3_not_yet", 32'(tx_timeout), 32'd0);
      chk("t3_wait", 32'(dut.state_q), 32'(WAIT_ACK));
      tick();
      chk("t3_timeout", 32'(tx_timeout), 32'd1);
      chk("t3_idle", 32'(dut.state_q), 32'(IDLE));
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      chk("t3_cleared", 32'(tx_timeout), 32'd0);
      auto_ack = 1'b1;
      base = sent_q.size();
      push_tx(8'h5A);
      wait_sent("t3_next_sent", base + 1, 20);
      tick(6);
      chk("t3_next_word", 32'(sent_q[sent_q.size() - 1]), 32'h5A);
      chk("t3_no_timeout", 32'(tx_timeout), 32'd0);

      // RX overrun: 9 strobes into an 8-deep FIFO.
      strobe_rx(8'h11);
      chk("t4_valid_e0", 32'(sd_rx_valid), 32'd1);
      for (int i = 1; i < 9; i++) strobe_rx(8'(8'h11 + i));
      chk("t4_count", 32'(rx_count), 32'd8);
      chk("t4_overrun", 32'(rx_overrun), 32'd1);
      for (int i = 0; i < 8; i++) begin
         chk("t4_read", 32'(sd_rx_data), 32'(8'h11 + i));
         sd_rx_rd = 1'b1;
         tick();
         sd_rx_rd = 1'b0;
      end
      chk("t4_empty", 32'(sd_rx_valid), 32'd0);
      sd_rx_rd = 1'b1;
      tick();
      sd_rx_rd = 1'b0;
      chk("t4_pop_empty", 32'(rx_count), 32'd0);
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      chk("t4_clr", 32'(rx_overrun), 32'd0);

      // Full RX with simultaneous push and pop; set beats clear in the same cycle.
      for (int i = 0; i < 8; i++) strobe_rx(8'(8'h21 + i));
      uart_rx_valid = 1'b1;
      uart_rx_data = 8'h99;
      sd_rx_rd = 1'b1;
      status_clr = 1'b1;
      tick();
      uart_rx_valid = 1'b0;
      sd_rx_rd = 1'b0;
      status_clr = 1'b0;
      chk("t5_overrun", 32'(rx_overrun), 32'd1);
      chk("t5_count", 32'(rx_count), 32'd7);
      for (int i = 1; i < 8; i++) begin
         chk("t5_read", 32'(sd_rx_data), 32'(8'h21 + i));
         sd_rx_rd = 1'b1;
         tick();
         sd_rx_rd = 1'b0;
      end
      chk("t5_empty", 32'(sd_rx_valid), 32'd0);

      // Async reset during START kills the pulse immediately.
      auto_ack = 1'b0;
      man_sending = 1'b0;
      push_tx(8'h61);
      tick();
      chk("t6_en_start", 32'(uart_tx_en), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_en_async", 32'(uart_tx_en), 32'd0);
      tick();
      rst = 1'b0;

      // Reset while BUSY with three words queued.
      man_sending = 1'b1;
      push_tx(8'h41);
      tick(3);
      push_tx(8'h42);
      push_tx(8'h43);
      push_tx(8'h44);
      chk("t7_busy", 32'(dut.state_q), 32'(BUSY));
      chk("t7_queued", 32'(tx_count), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("t7_count0", 32'(tx_count), 32'd0);
      chk("t7_idle", 32'(dut.state_q), 32'(IDLE));
      chk("t7_en0", 32'(uart_tx_en), 32'd0);
      tick();
      rst = 1'b0;
      man_sending = 1'b0;
      auto_ack = 1'b1;
      base = sent_q.size();
      push_tx(8'h77);
      wait_sent("t7_next_sent", base + 1, 20);
      tick(6);
      chk("t7_next_word", 32'(sent_q[sent_q.size() - 1]), 32'h77);
      chk("t7_final_idle", 32'(dut.state_q), 32'(IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
